// File: rtl/uart_receiver.sv
// UART receiver for 11-bit frames (start, D0..D7, parity, stop); byte and flags appear the cycle after the stop-bit sample edge.
// No backpressure: o_Rxdone is a one-cycle strobe and the byte holds until the next frame completes or reset.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_Rxdatain,
  output logic [7:0] o_Rxdataout,
  output logic       o_Rxdone,
  output logic       o_parityerr,
  output logic       o_frameerr,
  output logic       o_busy
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  // With HALF=0 the start bit is confirmed on the very edge it is first seen.
  localparam logic [2:0]    AFTER_IDLE = (HALF == 0) ? S_DATA : S_START;
  localparam logic [CW-1:0] FIRST_CNT  = CW'((HALF == 0) ? 0 : 1);
  localparam logic [CW-1:0] HALF_CNT   = CW'(HALF);
  localparam logic [CW-1:0] LAST_CNT   = CW'(CLKS_PER_BIT - 1);

  logic [2:0]    state;
  logic [CW-1:0] sub_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_err;
  logic          sample;

  assign sample = (sub_cnt == LAST_CNT);
  assign o_busy = (state == S_START) || (state == S_DATA) ||
                  (state == S_PARITY) || (state == S_STOP);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_IDLE;
      sub_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      par_err     <= 1'b0;
      o_Rxdataout <= '0;
      o_Rxdone    <= 1'b0;
      o_parityerr <= 1'b0;
      o_frameerr  <= 1'b0;
    end else begin
      o_Rxdone <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!i_Rxdatain) begin
            state   <= AFTER_IDLE;
            sub_cnt <= FIRST_CNT;
            bit_cnt <= '0;
          end
        end
        S_START: begin
          if (sub_cnt == HALF_CNT) begin
            sub_cnt <= '0;
            state   <= i_Rxdatain ? S_IDLE : S_DATA;
          end else begin
            sub_cnt <= sub_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (sample) begin
            sub_cnt <= '0;
            shift   <= {i_Rxdatain, shift[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) state <= S_PARITY;
          end else begin
            sub_cnt <= sub_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (sample) begin
            sub_cnt <= '0;
            par_err <= i_Rxdatain ^ (^shift) ^ PARITY_ODD;
            state   <= S_STOP;
          end else begin
            sub_cnt <= sub_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (sample) begin
            sub_cnt     <= '0;
            o_Rxdataout <= shift;
            o_parityerr <= par_err;
            o_frameerr  <= ~i_Rxdatain;
            o_Rxdone    <= 1'b1;
            // A low stop bit parks in BREAK so a held-low line cannot spawn frames.
            state       <= i_Rxdatain ? S_IDLE : S_BREAK;
          end else begin
            sub_cnt <= sub_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (i_Rxdatain) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frame table plus random frames on a 1-clk/bit even-parity
// instance and a 16-clk/bit odd-parity instance, checked by a frame-level scoreboard.
module tb_uart_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, rst16, rx1, rx16;
  logic [7:0] d1, d16;
  logic       dn1, dn16, pe1, pe16, fe1, fe16, by1, by16;

  uart_receiver #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) dut1 (
    .i_clk(clk), .i_reset(rst1), .i_Rxdatain(rx1),
    .o_Rxdataout(d1), .o_Rxdone(dn1), .o_parityerr(pe1), .o_frameerr(fe1), .o_busy(by1));

  uart_receiver #(.CLKS_PER_BIT(16), .PARITY_ODD(1'b1)) dut16 (
    .i_clk(clk), .i_reset(rst16), .i_Rxdatain(rx16),
    .o_Rxdataout(d16), .o_Rxdone(dn16), .o_parityerr(pe16), .o_frameerr(fe16), .o_busy(by16));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] d;
    bit         pe;
    bit         fe;
    int         at;
  } exp_t;

  exp_t q1[$];
  exp_t q16[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Each done pulse must match the oldest outstanding frame: data, flags and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (dn1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected done: got data=%0h at cycle %0d want no done", d1, cyc);
      end else begin
        e = q1.pop_front();
        check("dut1 frame {data,pe,fe,cycle}", {22'd0, d1, pe1, fe1, 32'(cyc)},
              {22'd0, e.d, e.pe, e.fe, 32'(e.at)});
      end
    end
    if (dn16 === 1'b1) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut16 unexpected done: got data=%0h at cycle %0d want no done", d16, cyc);
      end else begin
        e = q16.pop_front();
        check("dut16 frame {data,pe,fe,cycle}", {22'd0, d16, pe16, fe16, 32'(cyc)},
              {22'd0, e.d, e.pe, e.fe, 32'(e.at)});
      end
    end
  end

  task automatic set_line(input int w, input logic b);
    if (w == 0) rx1 = b; else rx16 = b;
  endtask

  task automatic hold(input int w, input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      set_line(w, b);
      @(posedge clk); @(negedge clk);
    end
  endtask

  function automatic logic [63:0] outs(input int w);
    if (w == 0) return {59'd0, d1 == 8'd0 ? 1'b0 : 1'b1, dn1, pe1, fe1, by1};
    return {59'd0, d16 == 8'd0 ? 1'b0 : 1'b1, dn16, pe16, fe16, by16};
  endfunction

  // Drives one frame starting at a negedge. rst_bit >= 0 pulses reset in that bit period
  // and abandons the rest of the frame.
  task automatic drive_frame(input int w, input logic [7:0] d, input logic par,
                             input logic stop, input int rst_bit,
                             input bit exp_pe, input bit exp_fe);
    int c = (w == 0) ? 1 : 16;
    int h = (c - 1) / 2;
    logic [10:0] fr;
    exp_t e;
    fr = {stop, par, d, 1'b0};
    if (rst_bit < 0) begin
      e.d = d; e.pe = exp_pe; e.fe = exp_fe; e.at = cyc + 1 + h + 10 * c;
      if (w == 0) q1.push_back(e); else q16.push_back(e);
    end
    for (int j = 0; j < 11 * c; j++) begin
      set_line(w, fr[j / c]);
      if (j == rst_bit * c) begin
        if (w == 0) rst1 = 1'b1; else rst16 = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      if (j == rst_bit * c) begin
        rst1 = 1'b0; rst16 = 1'b0;
        check($sformatf("w%0d reset at bit %0d outputs", w, rst_bit), outs(w), 64'd0);
        set_line(w, 1'b1);
        return;
      end
      if (j == 0) check($sformatf("w%0d busy after start", w), outs(w) & 64'd1, 64'd1);
      if (j == h + 10 * c) check($sformatf("w%0d busy after stop sample", w), outs(w) & 64'd1, 64'd0);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    bit         par_ok;
    bit         stop;
    int         low_hold;
    int         idle;
    bit         exp_pe;
    bit         exp_fe;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] rd;
    logic       rp, rs;
    int         odd;

    vecs[0] = '{8'h58, 1'b1, 1'b1, 0,  3, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 0,  0, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 0,  0, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 0,  4, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b0, 1'b1, 0,  2, 1'b1, 1'b0};
    vecs[5] = '{8'h3C, 1'b1, 1'b0, 20, 3, 1'b0, 1'b1};
    vecs[6] = '{8'h7E, 1'b1, 1'b1, 0,  3, 1'b0, 1'b0};

    rst1 = 1'b1; rst16 = 1'b1; rx1 = 1'b1; rx16 = 1'b1;
    repeat (3) @(negedge clk);
    check("dut1 reset outputs", outs(0), 64'd0);
    check("dut16 reset outputs", outs(1), 64'd0);
    rst1 = 1'b0; rst16 = 1'b0;
    hold(0, 1'b1, 2);

    for (int i = 0; i < 7; i++) begin
      rp = vecs[i].par_ok ? ^vecs[i].d : ~^vecs[i].d;
      drive_frame(0, vecs[i].d, rp, vecs[i].stop, -1, vecs[i].exp_pe, vecs[i].exp_fe);
      hold(0, 1'b0, vecs[i].low_hold);
      hold(0, 1'b1, vecs[i].idle);
    end

    // Reset mid-frame at D4 of 8'h99, then a clean 8'h66.
    drive_frame(0, 8'h99, ^8'h99, 1'b1, 5, 1'b0, 1'b0);
    hold(0, 1'b1, 4);
    drive_frame(0, 8'h66, ^8'h66, 1'b1, -1, 1'b0, 1'b0);
    hold(0, 1'b1, 2);
    // Reset on the stop-sample edge suppresses the done pulse.
    drive_frame(0, 8'h5A, ^8'h5A, 1'b1, 10, 1'b0, 1'b0);
    hold(0, 1'b1, 3);

    for (int i = 0; i < 40; i++) begin
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 4) != 0);
      drive_frame(0, rd, rp, rs, -1, rp ^ (^rd), ~rs);
      if (!rs) begin
        hold(0, 1'b0, $urandom_range(0, 5));
        hold(0, 1'b1, $urandom_range(1, 3));
      end else begin
        hold(0, 1'b1, $urandom_range(0, 3));
      end
    end
    hold(0, 1'b1, 4);

    // 16 clk/bit: a 3-cycle glitch must fall back to idle without a frame.
    hold(1, 1'b0, 3);
    check("dut16 busy during glitch", outs(1) & 64'd1, 64'd1);
    hold(1, 1'b1, 30);
    check("dut16 idle after glitch", outs(1) & 64'd1, 64'd0);
    drive_frame(1, 8'hC3, ~^8'hC3, 1'b1, -1, 1'b0, 1'b0);
    hold(1, 1'b1, 5);

    odd = 1;
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) != 0);
      drive_frame(1, rd, rp, rs, -1, rp ^ (^rd) ^ 1'(odd), ~rs);
      if (!rs) begin
        hold(1, 1'b0, $urandom_range(0, 40));
        hold(1, 1'b1, $urandom_range(1, 20));
      end else begin
        hold(1, 1'b1, $urandom_range(0, 20));
      end
    end
    hold(1, 1'b1, 20);

    check("dut1 frames outstanding", 64'(q1.size()), 64'd0);
    check("dut16 frames outstanding", 64'(q16.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
